// File: rtl/hssl_arb_pkg.sv
// Shared constants and types for the HSSL channel arbiter.
// The per-channel statistics are built only when HSSL_ARB_STATS_EN is defined.
package hssl_arb_pkg;
    localparam int unsigned HSSL_PACKET_BITS  = 72;
    localparam int unsigned HSSL_NUM_CHANNELS = 8;
    localparam int unsigned HSSL_CHAN_BITS    = $clog2(HSSL_NUM_CHANNELS);
    localparam int unsigned STAT_BITS         = 32;

    typedef logic [HSSL_CHAN_BITS-1:0]   chan_t;
    typedef logic [HSSL_PACKET_BITS-1:0] pkt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/hssl_chan_arbiter_rr_pick.sv
// Combinational round-robin pick: the first request at or above last+1, with wraparound.
// NUM_CHANNELS must be a power of two so that the index arithmetic wraps by itself.
module rr_pick
    import hssl_arb_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = HSSL_NUM_CHANNELS,
    parameter int unsigned CHAN_BITS    = HSSL_CHAN_BITS
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [CHAN_BITS-1:0]    last,
    output logic                    gnt_vld,
    output logic [CHAN_BITS-1:0]    gnt_idx
);

    logic [CHAN_BITS-1:0]      start;
    logic [2*NUM_CHANNELS-1:0] req2;
    logic [NUM_CHANNELS-1:0]   rot;
    logic [CHAN_BITS-1:0]      off;
    logic                      found;

    always_comb begin
        start   = last + CHAN_BITS'(1);
        // Shifting the doubled vector rotates req so that bit 0 is the channel at 'start'.
        req2    = {req, req} >> start;
        rot     = req2[NUM_CHANNELS-1:0];
        gnt_vld = |rot;
        off     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (rot[i] && !found) begin
                off   = CHAN_BITS'(i);
                found = 1'b1;
            end
        end
        gnt_idx = start + off;
    end

endmodule

// File: rtl/hssl_chan_arbiter.sv
// Round-robin arbiter that merges NUM_CHANNELS packet channels into one registered,
// channel-tagged HSSL stream. Define HSSL_ARB_STATS_EN to add per-channel packet counters.
module hssl_chan_arbiter
    import hssl_arb_pkg::*;
#(
    parameter int unsigned PACKET_BITS  = HSSL_PACKET_BITS,
    parameter int unsigned NUM_CHANNELS = HSSL_NUM_CHANNELS,
    parameter int unsigned CHAN_BITS    = HSSL_CHAN_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             chan_en_in,
    input  logic [NUM_CHANNELS*PACKET_BITS-1:0] pkt_in_data_in,
    input  logic [NUM_CHANNELS-1:0]             pkt_in_vld_in,
    output logic [NUM_CHANNELS-1:0]             pkt_in_rdy_out,
    output logic [PACKET_BITS-1:0]              pkt_out_data_out,
    output logic [CHAN_BITS-1:0]                pkt_out_chan_out,
    output logic                                pkt_out_vld_out,
    input  logic                                pkt_out_rdy_in
`ifdef HSSL_ARB_STATS_EN
   ,input  logic                                stat_clr_in,
    output logic [NUM_CHANNELS*STAT_BITS-1:0]   stat_cnt_out
`endif
);

    arb_state_e              state_q, state_d;
    logic [PACKET_BITS-1:0]  data_q, data_d;
    logic [CHAN_BITS-1:0]    chan_q, chan_d;
    logic [CHAN_BITS-1:0]    last_q, last_d;

    logic                    load;
    logic [NUM_CHANNELS-1:0] req;
    logic                    gnt_vld;
    logic [CHAN_BITS-1:0]    gnt_idx;

    rr_pick #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CHAN_BITS   (CHAN_BITS)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .gnt_vld(gnt_vld),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        // Arbitrate whenever the output register is empty or is being drained this cycle.
        load           = (state_q == ST_EMPTY) || pkt_out_rdy_in;
        req            = pkt_in_vld_in & chan_en_in;
        pkt_in_rdy_out = '0;
        state_d        = state_q;
        data_d         = data_q;
        chan_d         = chan_q;
        last_d         = last_q;
        if (load) begin
            if (gnt_vld) begin
                pkt_in_rdy_out[gnt_idx] = 1'b1;
                data_d  = pkt_in_data_in[gnt_idx*PACKET_BITS +: PACKET_BITS];
                chan_d  = gnt_idx;
                last_d  = gnt_idx;
                state_d = ST_FULL;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= CHAN_BITS'(NUM_CHANNELS - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

    assign pkt_out_vld_out  = (state_q == ST_FULL);
    assign pkt_out_data_out = data_q;
    assign pkt_out_chan_out = chan_q;

`ifdef HSSL_ARB_STATS_EN
    logic [STAT_BITS-1:0] cnt_q [NUM_CHANNELS];
    logic [STAT_BITS-1:0] cnt_d [NUM_CHANNELS];
    logic                 xfer;

    always_comb begin
        xfer  = (state_q == ST_FULL) && pkt_out_rdy_in;
        cnt_d = cnt_q;
        if (stat_clr_in) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                cnt_d[i] = '0;
            end
        end else if (xfer) begin
            cnt_d[chan_q] = cnt_q[chan_q] + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        stat_cnt_out = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            stat_cnt_out[i*STAT_BITS +: STAT_BITS] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_hssl_chan_arbiter.sv
// Self-checking bench for hssl_chan_arbiter: directed scenarios plus random traffic
// compared against a cycle-level reference model. Honours HSSL_ARB_STATS_EN.
module tb_hssl_chan_arbiter;
    localparam int unsigned N  = 8;
    localparam int unsigned PB = 72;
    localparam int unsigned CB = 3;
    localparam int unsigned SB = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        chan_en_in;
    logic [N*PB-1:0]     pkt_in_data_in;
    logic [N-1:0]        pkt_in_vld_in;
    logic [N-1:0]        pkt_in_rdy_out;
    logic [PB-1:0]       pkt_out_data_out;
    logic [CB-1:0]       pkt_out_chan_out;
    logic                pkt_out_vld_out;
    logic                pkt_out_rdy_in;
`ifdef HSSL_ARB_STATS_EN
    logic                stat_clr_in;
    logic [N*SB-1:0]     stat_cnt_out;
`endif

    logic [PB-1:0] data_a [N];

    // Reference model state
    logic          m_vld;
    logic [PB-1:0] m_data;
    int            m_chan;
    int unsigned   m_last;
    logic [SB-1:0] m_cnt [N];
    int            last_g;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    always_comb begin
        pkt_in_data_in = '0;
        for (int unsigned i = 0; i < N; i++) pkt_in_data_in[i*PB +: PB] = data_a[i];
    end

    hssl_chan_arbiter #(
        .PACKET_BITS (PB),
        .NUM_CHANNELS(N),
        .CHAN_BITS   (CB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .chan_en_in      (chan_en_in),
        .pkt_in_data_in  (pkt_in_data_in),
        .pkt_in_vld_in   (pkt_in_vld_in),
        .pkt_in_rdy_out  (pkt_in_rdy_out),
        .pkt_out_data_out(pkt_out_data_out),
        .pkt_out_chan_out(pkt_out_chan_out),
        .pkt_out_vld_out (pkt_out_vld_out),
        .pkt_out_rdy_in  (pkt_out_rdy_in)
`ifdef HSSL_ARB_STATS_EN
       ,.stat_clr_in     (stat_clr_in),
        .stat_cnt_out    (stat_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PB-1:0] rand_pkt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[PB-1:0];
    endfunction

    task automatic model_reset();
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_last = N - 1;
        for (int unsigned i = 0; i < N; i++) m_cnt[i] = '0;
        last_g = -1;
    endtask

    // One clock: check accept strobes before the edge, advance the model, check outputs after.
    // Entered and left at a falling edge; inputs must be settled on entry.
    task automatic step();
        int           g;
        logic         load;
        logic [N-1:0] exp_rdy;
        #1;
        load = !m_vld || pkt_out_rdy_in;
        g = -1;
        if (load) begin
            for (int unsigned k = 1; k <= N; k++) begin
                int unsigned c;
                c = (m_last + k) % N;
                if (g < 0 && pkt_in_vld_in[c] && chan_en_in[c]) g = int'(c);
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("rdy_out", pkt_in_rdy_out, exp_rdy);
        @(posedge clk);
`ifdef HSSL_ARB_STATS_EN
        if (stat_clr_in) begin
            for (int unsigned i = 0; i < N; i++) m_cnt[i] = '0;
        end else if (m_vld && pkt_out_rdy_in) begin
            m_cnt[m_chan] = m_cnt[m_chan] + 1;
        end
`endif
        if (load) begin
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_data = data_a[g];
                m_chan = g;
                m_last = g;
            end else begin
                m_vld = 1'b0;
            end
        end
        last_g = g;
        #1;
        check("vld_out", pkt_out_vld_out, m_vld);
        if (m_vld) begin
            check("chan_out", pkt_out_chan_out, m_chan);
            check("data_out", pkt_out_data_out, m_data);
        end
`ifdef HSSL_ARB_STATS_EN
        for (int unsigned i = 0; i < N; i++) check("stat_cnt", stat_cnt_out[i*SB +: SB], m_cnt[i]);
`endif
        if (g >= 0) data_a[g] = rand_pkt();
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [PB-1:0] held;

        reset          = 1'b1;
        chan_en_in     = '1;
        pkt_in_vld_in  = '0;
        pkt_out_rdy_in = 1'b1;
`ifdef HSSL_ARB_STATS_EN
        stat_clr_in    = 1'b0;
`endif
        for (int unsigned i = 0; i < N; i++) data_a[i] = rand_pkt();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_vld", pkt_out_vld_out, 1'b0);
        check("rst_data", pkt_out_data_out, '0);
        check("rst_chan", pkt_out_chan_out, '0);
        reset = 1'b0;

        // 1: every channel valid, output always accepted -> tags cycle 0..7 with no gaps
        pkt_in_vld_in = '1;
        for (int unsigned i = 0; i < 16; i++) begin
            step();
            check("t1_vld", pkt_out_vld_out, 1'b1);
            check("t1_seq", pkt_out_chan_out, i % N);
        end

        // 2: only channels 3 and 5 valid -> strict alternation
        pkt_in_vld_in = 8'b0010_1000;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            check("t2_alt", pkt_out_chan_out, (i % 2 == 0) ? 3 : 5);
        end

        // 3: ch2 granted, framer stalls while ch2 offers new data, then ch3 follows
        pkt_in_vld_in = 8'b0000_1100;
        step();
        check("t3_grant2", pkt_out_chan_out, 2);
        held = pkt_out_data_out;
        pkt_out_rdy_in = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            data_a[2] = rand_pkt();
            step();
            check("t3_hold_chan", pkt_out_chan_out, 2);
            check("t3_hold_data", pkt_out_data_out, held);
            check("t3_no_rdy", pkt_in_rdy_out, '0);
        end
        pkt_out_rdy_in = 1'b1;
        step();
        check("t3_next3", pkt_out_chan_out, 3);

        // 4: channel 0 disabled -> never granted; re-enabled -> granted within 8 cycles
        pkt_in_vld_in = '1;
        chan_en_in    = 8'hFE;
        for (int unsigned i = 0; i < 12; i++) begin
            step();
            check("t4_no_ch0", (pkt_out_chan_out == 0), 1'b0);
        end
        chan_en_in = '1;
        seen = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            step();
            if (pkt_out_vld_out && pkt_out_chan_out == 0) seen = 1;
        end
        check("t4_ch0_regrant", seen, 1);

        // 5: asynchronous reset with a packet held drops it at once; restart from channel 0
        check("t5_pre_vld", pkt_out_vld_out, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_vld", pkt_out_vld_out, 1'b0);
        check("t5_rst_chan", pkt_out_chan_out, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        pkt_in_vld_in = 8'b0101_0000;
        step();
        check("t5_first", pkt_out_chan_out, 4);

`ifdef HSSL_ARB_STATS_EN
        // 6: ten packets on ch6, clear coincident with the eleventh transfer
        stat_clr_in   = 1'b1;
        pkt_in_vld_in = 8'b0100_0000;
        step();
        stat_clr_in = 1'b0;
        for (int unsigned i = 0; i < 40 && m_cnt[6] != 10; i++) step();
        check("t6_ten", stat_cnt_out[6*SB +: SB], 10);
        stat_clr_in = 1'b1;
        step();
        stat_clr_in = 1'b0;
        check("t6_clr", stat_cnt_out[6*SB +: SB], 0);
`endif

        // Random traffic obeying the upstream hold-until-accepted rule
        for (int unsigned cyc = 0; cyc < 400; cyc++) begin
            pkt_out_rdy_in = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) chan_en_in = N'($urandom());
            else if ($urandom_range(0, 9) == 0) chan_en_in = '1;
            for (int unsigned c = 0; c < N; c++) begin
                if (!pkt_in_vld_in[c]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pkt_in_vld_in[c] = 1'b1;
                        data_a[c] = rand_pkt();
                    end
                end else if (int'(c) == last_g && $urandom_range(0, 2) == 0) begin
                    pkt_in_vld_in[c] = 1'b0;
                end
            end
`ifdef HSSL_ARB_STATS_EN
            stat_clr_in = ($urandom_range(0, 19) == 0);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
